// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer: FSM state encoding and control-word bit positions.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pwm_state_e;

    localparam int EN_BIT      = 0;
    localparam int INV_BIT     = 1;
    localparam int ONESHOT_BIT = 2;
    localparam int IRQEN_BIT   = 3;

endpackage

// File: rtl/pwm_timer_core.sv
// PWM timer core: free-running or one-shot counter with shadowed period/duty/invert,
// registered PWM output and a sticky wrap interrupt.
module pwm_timer_core
    import pwm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] period_reg,
    input  logic [WIDTH-1:0] duty_reg,
    input  logic [31:0]      ctrl_reg,
    input  logic             irq_clear,
    output logic             pwm_out,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             irq
);

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic             inv_sh_q, inv_sh_d;
    logic             pwm_q, pwm_d;
    logic             irq_q, irq_d;
    logic             irq_set_s;
    logic [WIDTH-1:0] count_inc_s;

    logic en_s, inv_s, oneshot_s, irqen_s;
    logic unused_ctrl_s;

    assign en_s          = ctrl_reg[EN_BIT];
    assign inv_s         = ctrl_reg[INV_BIT];
    assign oneshot_s     = ctrl_reg[ONESHOT_BIT];
    assign irqen_s       = ctrl_reg[IRQEN_BIT];
    assign unused_ctrl_s = &{1'b0, ctrl_reg[31:4]};
    assign count_inc_s   = count_q + WIDTH'(1);

    // Next-state, counter, shadow reload and PWM level for the count presented next cycle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        inv_sh_d    = inv_sh_q;
        pwm_d       = pwm_q;
        irq_set_s   = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (en_s && (period_reg != '0)) begin
                    state_d     = RUN;
                    period_sh_d = period_reg;
                    duty_sh_d   = duty_reg;
                    inv_sh_d    = inv_s;
                    pwm_d       = (duty_reg != '0) ^ inv_s;
                end else begin
                    pwm_d = inv_s;
                end
            end
            RUN: begin
                if (!en_s) begin
                    state_d = IDLE;
                    count_d = '0;
                    pwm_d   = inv_s;
                end else if (count_q == period_sh_q) begin
                    count_d = '0;
                    if (oneshot_s) begin
                        state_d   = DONE;
                        irq_set_s = irqen_s;
                        pwm_d     = inv_sh_q;
                    end else if (period_reg == '0) begin
                        // A zero period cannot form a cycle, so stop without an interrupt.
                        state_d = IDLE;
                        pwm_d   = inv_s;
                    end else begin
                        irq_set_s   = irqen_s;
                        period_sh_d = period_reg;
                        duty_sh_d   = duty_reg;
                        inv_sh_d    = inv_s;
                        pwm_d       = (duty_reg != '0) ^ inv_s;
                    end
                end else begin
                    count_d = count_inc_s;
                    pwm_d   = (count_inc_s < duty_sh_q) ^ inv_sh_q;
                end
            end
            DONE: begin
                count_d = '0;
                if (!en_s) begin
                    state_d = IDLE;
                    pwm_d   = inv_s;
                end else begin
                    pwm_d = inv_sh_q;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                pwm_d   = inv_s;
            end
        endcase

        // Set beats clear when both land on the same edge.
        irq_d = irq_set_s | (irq_q & ~irq_clear);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            inv_sh_q    <= 1'b0;
            pwm_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            inv_sh_q    <= inv_sh_d;
            pwm_q       <= pwm_d;
            irq_q       <= irq_d;
        end
    end

    assign pwm_out = pwm_q;
    assign count   = count_q;
    assign busy    = (state_q != IDLE);
    assign irq     = irq_q;

endmodule

// File: tb/tb_pwm_timer_core.sv
// Directed bench for pwm_timer_core: per-cycle vector table plus hand sequences.
module tb_pwm_timer_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] period_reg;
    logic [31:0] duty_reg;
    logic [31:0] ctrl_reg;
    logic        irq_clear;
    logic        pwm_out;
    logic [31:0] count;
    logic        busy;
    logic        irq;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_timer_core #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .period_reg (period_reg),
        .duty_reg   (duty_reg),
        .ctrl_reg   (ctrl_reg),
        .irq_clear  (irq_clear),
        .pwm_out    (pwm_out),
        .count      (count),
        .busy       (busy),
        .irq        (irq)
    );

    typedef struct {
        logic        rst;
        logic [31:0] per;
        logic [31:0] duty;
        logic [31:0] ctrl;
        logic        clr;
        logic [31:0] e_cnt;
        logic        e_pwm;
        logic        e_busy;
        logic        e_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic [31:0] p, logic [31:0] d, logic [31:0] c,
                                logic cl, logic [31:0] ec, logic ep, logic eb, logic ei);
        vec_t v;
        v.rst = r; v.per = p; v.duty = d; v.ctrl = c; v.clr = cl;
        v.e_cnt = ec; v.e_pwm = ep; v.e_busy = eb; v.e_irq = ei;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] ec, logic ep, logic eb, logic ei);
        n_run++;
        if (count !== ec || pwm_out !== ep || busy !== eb || irq !== ei) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d pwm=%b busy=%b irq=%b, want cnt=%0d pwm=%b busy=%b irq=%b",
                     nm, count, pwm_out, busy, irq, ec, ep, eb, ei);
        end
    endtask

    initial begin
        reset = 1'b1; period_reg = 32'd0; duty_reg = 32'd0; ctrl_reg = 32'd0; irq_clear = 1'b0;

        // Continuous run, irq enabled, upper ctrl bits set and ignored.
        add(1'b1, 32'd0, 32'd0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hF000_0009, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hF000_0009, 1'b0, 32'd1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hF000_0009, 1'b0, 32'd2, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hF000_0009, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hF000_0009, 1'b0, 32'd4, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hF000_0009, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 32'd4, 32'd2, 32'hF000_0009, 1'b0, 32'd1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 32'd4, 32'd2, 32'hF000_0009, 1'b0, 32'd2, 1'b0, 1'b1, 1'b1);
        add(1'b0, 32'd4, 32'd2, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'd4, 32'd2, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        // Inverted output; clear coinciding with wrap loses to set.
        add(1'b0, 32'd4, 32'd2, 32'hB, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hB, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hB, 1'b0, 32'd2, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hB, 1'b0, 32'd3, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hB, 1'b0, 32'd4, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'hB, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 32'd4, 32'd2, 32'hB, 1'b1, 32'd1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'h2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'd4, 32'd2, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        // One-shot: single pattern, hold in DONE, release to IDLE.
        add(1'b0, 32'd3, 32'd1, 32'h5, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'd3, 32'd1, 32'h5, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd3, 32'd1, 32'h5, 1'b0, 32'd2, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd3, 32'd1, 32'h5, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd3, 32'd1, 32'h5, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd3, 32'd1, 32'h5, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd3, 32'd1, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        // EN with zero period stays idle.
        add(1'b0, 32'd0, 32'd2, 32'h9, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'd0, 32'd2, 32'h9, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        // Zero period seen at reload: no truncation, then IDLE without irq.
        add(1'b0, 32'd2, 32'd1, 32'h9, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'd2, 32'd1, 32'h9, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd0, 32'd1, 32'h9, 1'b0, 32'd2, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd0, 32'd1, 32'h9, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'd0, 32'd1, 32'h9, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        // Raise irq, then reset mid-run at count 5.
        add(1'b0, 32'd1, 32'd1, 32'h9, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'd1, 32'd1, 32'h9, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'd1, 32'd1, 32'h9, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 32'd1, 32'd1, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'd9, 32'd3, 32'h9, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 32'd9, 32'd3, 32'h9, 1'b0, 32'd1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 32'd9, 32'd3, 32'h9, 1'b0, 32'd2, 1'b1, 1'b1, 1'b1);
        add(1'b0, 32'd9, 32'd3, 32'h9, 1'b0, 32'd3, 1'b0, 1'b1, 1'b1);
        add(1'b0, 32'd9, 32'd3, 32'h9, 1'b0, 32'd4, 1'b0, 1'b1, 1'b1);
        add(1'b0, 32'd9, 32'd3, 32'h9, 1'b0, 32'd5, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'd9, 32'd3, 32'h9, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'd9, 32'd3, 32'h2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'd9, 32'd3, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            reset      = vecs[i].rst;
            period_reg = vecs[i].per;
            duty_reg   = vecs[i].duty;
            ctrl_reg   = vecs[i].ctrl;
            irq_clear  = vecs[i].clr;
            step();
            chk($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_pwm, vecs[i].e_busy, vecs[i].e_irq);
        end

        // Period shrink mid-cycle: old cycle finishes at 9, then cycles of length 3.
        reset = 1'b0; irq_clear = 1'b0;
        period_reg = 32'd9; duty_reg = 32'd3; ctrl_reg = 32'h1;
        step();
        chk("shrink_start", 32'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("shrink_pre%0d", k), 32'(k), (k < 3), 1'b1, 1'b0);
        end
        period_reg = 32'd2;
        for (int k = 4; k <= 9; k++) begin
            step();
            chk($sformatf("shrink_old%0d", k), 32'(k), 1'b0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("shrink_new%0d", k), 32'(k % 3), 1'b1, 1'b1, 1'b0);
        end
        // Duty 0 gives constant inactive, duty above period gives constant active.
        duty_reg = 32'd0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("duty0_%0d", k), 32'(k % 3), 1'b0, 1'b1, 1'b0);
        end
        duty_reg = 32'd20;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("duty20_%0d", k), 32'(k % 3), 1'b1, 1'b1, 1'b0);
        end
        ctrl_reg = 32'h0;
        step();
        chk("shrink_stop", 32'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_timer_core.md
PWM_TIMER_CORE -- requirements
Module: pwm_timer_core

Interface
REQ-001 Parameter: WIDTH, default 32, width of the period, duty and counter datapath.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: period_reg  in  WIDTH  terminal count; PWM cycle length is period_reg+1 clocks; driven by the Avalon register peripheral (reg1).
REQ-005 Port: duty_reg  in  WIDTH  active-phase length in clocks (reg2).
REQ-006 Port: ctrl_reg  in  32  control word (reg3): bit0 EN, bit1 INV, bit2 ONESHOT, bit3 IRQ_EN; bits 31:4 ignored.
REQ-007 Port: irq_clear  in  1  single-cycle pulse that clears the pending interrupt.
REQ-008 Port: pwm_out  out  1  registered PWM output.
REQ-009 Port: count  out  WIDTH  current counter value, for status readback.
REQ-010 Port: busy  out  1  high when the state is not IDLE.
REQ-011 Port: irq  out  1  sticky interrupt request.

Function
REQ-012 States: IDLE, RUN, DONE, held in a registered state variable.
REQ-013 IDLE->RUN: when EN=1 and period_reg!=0; in the same edge, latch period_reg, duty_reg and INV into shadow registers and set count=0.
REQ-014 In IDLE, count=0 and pwm_out=INV (inactive level, taken from live ctrl_reg).
REQ-015 RUN: count increments by 1 per clock; when count==period_sh it wraps to 0, and the shadows reload from the live inputs on that same edge.
REQ-016 pwm_out = (count < duty_sh) XOR inv_sh, using unsigned compare; it is registered so that it aligns with the count value presented in the same cycle.
REQ-017 duty_sh=0 gives a constant inactive level; duty_sh>period_sh gives a constant active level.
REQ-018 Wrap event: if IRQ_EN=1, set irq at the wrap edge.
REQ-019 irq stays set until irq_clear=1; if set and clear coincide, set wins.
REQ-020 ONESHOT=1 in RUN: at the first wrap, go to DONE instead of reloading; count=0 and pwm_out is inactive.
REQ-021 DONE is held while EN=1; EN=0 gives DONE->IDLE.
REQ-022 EN=0 in RUN: go to IDLE on the next edge, abandoning the current cycle with no wrap and no irq.
REQ-023 period_reg writes in RUN take effect only at the next wrap, so the cycle in progress is never truncated.
REQ-024 A live period_reg of 0 seen at reload: go to IDLE and do not set irq.
REQ-025 EN=1 with period_reg=0 in IDLE: remain in IDLE.
REQ-026 busy=1 in RUN and DONE.
REQ-027 ctrl bits 31:4 have no effect.

Reset
REQ-028 reset=1 at a clock edge forces: state=IDLE, count=0, all shadow registers=0, irq=0, pwm_out=0.
REQ-029 pwm_out follows live INV from the first post-reset cycle.
REQ-030 reset overrides every other input, including a reset asserted mid-cycle in RUN or DONE.

Structure
REQ-031 Shared package pwm_pkg holds the state enum (IDLE, RUN, DONE) and the ctrl bit-index constants EN_BIT=0, INV_BIT=1, ONESHOT_BIT=2, IRQEN_BIT=3.
REQ-032 The block is a single module with no sub-modules; the counter, compare, FSM and irq logic are all in pwm_timer_core.

Verification
REQ-033 period=4, duty=2, ctrl=0x9, then run 15 clocks -> pwm_out pattern 1,1,0,0,0 repeats with period 5; irq set at the first wrap; count sequence 0..4.
REQ-034 Same as REQ-033 with ctrl=0xB (INV) -> pattern 0,0,1,1,1; irq_clear on the same cycle as a wrap -> irq stays 1.
REQ-035 period=3, duty=1, ctrl=0x5 (ONESHOT) -> exactly one pattern 1,0,0,0, then DONE with busy=1 and pwm_out=0; clearing EN -> IDLE, busy=0.
REQ-036 Running period=9, change period_reg to 2 at count=3 -> count continues to 9, then runs 0..2; duty=0 -> pwm_out constant 0; duty=20 -> pwm_out constant 1.
REQ-037 Assert reset at count=5 in RUN -> next cycle count=0, irq=0, busy=0, pwm_out=0.
REQ-038 EN=1 with period=0 -> stays in IDLE, busy=0, no irq.
